// File: rtl/phy_pkg.sv
// Shared PHY definitions: the COM/idle symbol used by both link directions and the receiver state encoding.
package phy_pkg;

  localparam logic [7:0] COM_SYMBOL = 8'hBC;

  typedef enum logic [1:0] {
    SEARCH = 2'd0,
    ALIGN  = 2'd1,
    ACTIVE = 2'd2
  } rx_state_e;

endpackage

// File: rtl/serial_paralelo_rx_if.sv
// Serial input and byte-wide output bundle of the PHY receiver.
interface serial_paralelo_rx_if;

  logic       data_in;
  logic [7:0] data_out;
  logic       valid_out;
  logic       byte_stb;
  logic       rx_active;

  modport master (
    output data_in,
    input  data_out,
    input  valid_out,
    input  byte_stb,
    input  rx_active
  );

  modport slave (
    input  data_in,
    output data_out,
    output valid_out,
    output byte_stb,
    output rx_active
  );

endinterface

// File: rtl/com_detector.sv
// Flags a COM symbol in the current 8-bit window and whether the window ends on a byte boundary.
module com_detector
  import phy_pkg::*;
(
  input  logic [7:0] win_i,
  input  logic [2:0] bit_cnt_i,
  output logic       com_o,
  output logic       boundary_o
);

  assign com_o      = (win_i == COM_SYMBOL);
  assign boundary_o = (bit_cnt_i == 3'd7);

endmodule

// File: rtl/serial_paralelo_rx.sv
// Serial-to-parallel receiver: slides over the bit stream until COM_NEEDED aligned COMs are seen,
// then emits one byte per 8 bits, flagging COM (idle) bytes as not valid.
module serial_paralelo_rx
  import phy_pkg::*;
#(
  parameter int unsigned COM_NEEDED = 4
) (
  input  logic                 clk_32f,
  input  logic                 reset_L,
  serial_paralelo_rx_if.slave  rx
);

  localparam logic [3:0] NEED = 4'(COM_NEEDED);

  rx_state_e  state_q;
  logic [7:0] sr_q;
  logic [2:0] bit_cnt_q;
  logic [3:0] com_cnt_q;
  logic [7:0] data_q;
  logic       valid_q;
  logic       stb_q;
  logic       active_q;

  logic [7:0] win;
  logic [2:0] bit_cnt_d;
  logic [3:0] com_cnt_d;
  logic       is_com;
  logic       at_boundary;

  // The window includes the bit arriving this cycle, so a byte is judged on the edge that samples its LSB.
  assign win       = {sr_q[6:0], rx.data_in};
  assign bit_cnt_d = bit_cnt_q + 3'd1;
  assign com_cnt_d = com_cnt_q + 4'd1;

  com_detector u_com_detector (
    .win_i      (win),
    .bit_cnt_i  (bit_cnt_q),
    .com_o      (is_com),
    .boundary_o (at_boundary)
  );

  always_ff @(posedge clk_32f or negedge reset_L) begin
    if (!reset_L) begin
      state_q   <= SEARCH;
      sr_q      <= 8'h00;
      bit_cnt_q <= 3'd0;
      com_cnt_q <= 4'd0;
      data_q    <= 8'h00;
      valid_q   <= 1'b0;
      stb_q     <= 1'b0;
      active_q  <= 1'b0;
    end else begin
      sr_q  <= win;
      stb_q <= 1'b0;
      if (state_q != SEARCH) begin
        bit_cnt_q <= bit_cnt_d;
      end
      case (state_q)
        SEARCH: begin
          if (is_com) begin
            com_cnt_q <= 4'd1;
            bit_cnt_q <= 3'd0;
            if (NEED == 4'd1) begin
              state_q  <= ACTIVE;
              active_q <= 1'b1;
            end else begin
              state_q <= ALIGN;
            end
          end
        end
        ALIGN: begin
          if (at_boundary) begin
            if (is_com) begin
              com_cnt_q <= com_cnt_d;
              if (com_cnt_d == NEED) begin
                state_q  <= ACTIVE;
                active_q <= 1'b1;
              end
            end else begin
              // Mismatch drops back to sliding search starting with the next bit.
              state_q   <= SEARCH;
              com_cnt_q <= 4'd0;
            end
          end
        end
        ACTIVE: begin
          if (at_boundary) begin
            data_q  <= win;
            valid_q <= !is_com;
            stb_q   <= 1'b1;
          end
        end
        default: state_q <= SEARCH;
      endcase
    end
  end

  assign rx.data_out  = data_q;
  assign rx.valid_out = valid_q;
  assign rx.byte_stb  = stb_q;
  assign rx.rx_active = active_q;

endmodule

// File: tb/tb_serial_paralelo_rx.sv
// Randomized bench for serial_paralelo_rx; expectations come from a bit-history model of lock and byte framing.
module tb_serial_paralelo_rx;
  import phy_pkg::*;

  localparam int NEED = 4;

  typedef struct {
    logic       act;
    logic       stb;
    logic [7:0] data;
    logic       valid;
  } exp_t;

  logic clk_32f = 1'b0;
  logic reset_L = 1'b0;
  int   checks   = 0;
  int   failures = 0;
  bit   hist[$];

  serial_paralelo_rx_if rx_if ();

  serial_paralelo_rx #(.COM_NEEDED(NEED)) dut (
    .clk_32f (clk_32f),
    .reset_L (reset_L),
    .rx      (rx_if)
  );

  always #5 clk_32f = ~clk_32f;

  // Byte ending at history index i (MSB first); bits before the start of history read as 0.
  function automatic logic [7:0] win_at(int i);
    logic [7:0] w = 8'h00;
    for (int j = 0; j < 8; j++) begin
      int idx = i - 7 + j;
      if (idx >= 0) w[7-j] = hist[idx];
    end
    return w;
  endfunction

  // Index of the bit completing the NEED-th consecutive aligned COM, or -1 if not locked yet.
  function automatic int find_lock();
    int n   = hist.size();
    int i   = 0;
    int com = 0;
    while (i < n) begin
      if (win_at(i) == COM_SYMBOL) begin
        com++;
        if (com == NEED) return i;
        i += 8;
      end else begin
        com = 0;
        i++;
      end
    end
    return -1;
  endfunction

  function automatic exp_t model();
    exp_t e;
    int   lk   = find_lock();
    int   last = hist.size() - 1;
    e.act = 1'b0; e.stb = 1'b0; e.data = 8'h00; e.valid = 1'b0;
    if (lk >= 0 && last >= lk) begin
      int m = (last - lk) / 8;
      e.act = 1'b1;
      if (m > 0) begin
        int b = lk + 8 * m;
        e.data  = win_at(b);
        e.valid = (e.data != COM_SYMBOL);
        e.stb   = (b == last);
      end
    end
    return e;
  endfunction

  task automatic drive_bit(input bit b);
    @(negedge clk_32f);
    rx_if.data_in = b;
    @(posedge clk_32f);
    if (reset_L) hist.push_back(b);
    #1;
  endtask

  task automatic pulse_reset();
    @(negedge clk_32f);
    reset_L = 1'b0;
    hist.delete();
    @(posedge clk_32f);
    #1;
    reset_L = 1'b1;
  endtask

  task automatic test_reset();
    rx_if.data_in = 1'b0;
    for (int i = 0; i < 5; i++) begin
      drive_bit(1'($urandom_range(0, 1)));
      checks++;
      if (rx_if.data_out !== 8'h00 || rx_if.valid_out !== 1'b0 ||
          rx_if.byte_stb !== 1'b0 || rx_if.rx_active !== 1'b0) begin
        failures++;
        $display("FAIL reset_hold: got data=%02h valid=%0b stb=%0b act=%0b, exp all 0",
                 rx_if.data_out, rx_if.valid_out, rx_if.byte_stb, rx_if.rx_active);
      end
    end
    hist.delete();
    reset_L = 1'b1;
    drive_bit(1'b0);
    checks++;
    if (rx_if.rx_active !== 1'b0) begin
      failures++;
      $display("FAIL reset_release: got act=%0b exp 0", rx_if.rx_active);
    end
  endtask

  task automatic test_lock();
    exp_t       e;
    logic [7:0] com_b = COM_SYMBOL;
    for (int i = 0; i < 3; i++) drive_bit(1'b0);
    for (int c = 0; c < NEED; c++) begin
      for (int k = 7; k >= 0; k--) begin
        drive_bit(com_b[k]);
        e = model();
        checks++;
        if (rx_if.rx_active !== e.act || rx_if.byte_stb !== 1'b0) begin
          failures++;
          $display("FAIL lock_seq com%0d bit%0d: got act=%0b stb=%0b, exp act=%0b stb=0",
                   c, k, rx_if.rx_active, rx_if.byte_stb, e.act);
        end
      end
    end
    checks++;
    if (rx_if.rx_active !== 1'b1) begin
      failures++;
      $display("FAIL lock_edge: got act=%0b exp 1", rx_if.rx_active);
    end
  endtask

  task automatic test_data();
    logic [7:0] bytes [2] = '{8'hA5, 8'h3C};
    exp_t       e;
    for (int b = 0; b < 2; b++) begin
      logic [7:0] v = bytes[b];
      for (int k = 7; k >= 0; k--) begin
        drive_bit(v[k]);
        e = model();
        checks++;
        if (rx_if.byte_stb !== e.stb || rx_if.data_out !== e.data) begin
          failures++;
          $display("FAIL data_cycle byte%0d bit%0d: got stb=%0b data=%02h, exp stb=%0b data=%02h",
                   b, k, rx_if.byte_stb, rx_if.data_out, e.stb, e.data);
        end
      end
      checks++;
      if (rx_if.data_out !== v || rx_if.valid_out !== 1'b1 || rx_if.byte_stb !== 1'b1) begin
        failures++;
        $display("FAIL data_byte %02h: got data=%02h valid=%0b stb=%0b, exp data=%02h valid=1 stb=1",
                 v, rx_if.data_out, rx_if.valid_out, rx_if.byte_stb, v);
      end
    end
  endtask

  task automatic test_idle();
    logic [7:0] bytes [3] = '{8'h5A, COM_SYMBOL, 8'h77};
    exp_t       e;
    for (int b = 0; b < 3; b++) begin
      logic [7:0] v = bytes[b];
      for (int k = 7; k >= 0; k--) begin
        drive_bit(v[k]);
        e = model();
        checks++;
        if (rx_if.rx_active !== e.act || rx_if.byte_stb !== e.stb ||
            rx_if.data_out !== e.data || rx_if.valid_out !== e.valid) begin
          failures++;
          $display("FAIL idle byte%0d bit%0d: got act=%0b stb=%0b data=%02h valid=%0b, exp %0b %0b %02h %0b",
                   b, k, rx_if.rx_active, rx_if.byte_stb, rx_if.data_out, rx_if.valid_out,
                   e.act, e.stb, e.data, e.valid);
        end
      end
      if (b == 1) begin
        checks++;
        if (rx_if.data_out !== COM_SYMBOL || rx_if.valid_out !== 1'b0 ||
            rx_if.byte_stb !== 1'b1 || rx_if.rx_active !== 1'b1) begin
          failures++;
          $display("FAIL idle_com: got data=%02h valid=%0b stb=%0b act=%0b, exp BC 0 1 1",
                   rx_if.data_out, rx_if.valid_out, rx_if.byte_stb, rx_if.rx_active);
        end
      end
    end
  endtask

  task automatic test_broken_align();
    logic [7:0] bytes [7] = '{COM_SYMBOL, COM_SYMBOL, 8'h00, COM_SYMBOL, COM_SYMBOL, COM_SYMBOL, COM_SYMBOL};
    exp_t       e;
    pulse_reset();
    for (int b = 0; b < 7; b++) begin
      logic [7:0] v = bytes[b];
      for (int k = 7; k >= 0; k--) begin
        drive_bit(v[k]);
        e = model();
        checks++;
        if (rx_if.rx_active !== e.act || rx_if.byte_stb !== e.stb) begin
          failures++;
          $display("FAIL broken_align byte%0d bit%0d: got act=%0b stb=%0b, exp act=%0b stb=%0b",
                   b, k, rx_if.rx_active, rx_if.byte_stb, e.act, e.stb);
        end
      end
      if (b == 5 || b == 6) begin
        checks++;
        if (rx_if.rx_active !== (b == 6)) begin
          failures++;
          $display("FAIL broken_align_lock byte%0d: got act=%0b exp %0b", b, rx_if.rx_active, b == 6);
        end
      end
    end
  endtask

  task automatic test_async_reset();
    logic [7:0] full = 8'hF0;
    logic [7:0] part = 8'h6D;
    logic [7:0] com_b = COM_SYMBOL;
    exp_t       e;
    for (int k = 7; k >= 0; k--) drive_bit(full[k]);
    for (int k = 7; k >= 5; k--) drive_bit(part[k]);
    checks++;
    if (rx_if.data_out !== 8'hF0 || rx_if.valid_out !== 1'b1 || rx_if.rx_active !== 1'b1) begin
      failures++;
      $display("FAIL async_pre: got data=%02h valid=%0b act=%0b, exp F0 1 1",
               rx_if.data_out, rx_if.valid_out, rx_if.rx_active);
    end
    @(negedge clk_32f);
    reset_L = 1'b0;
    hist.delete();
    #1;
    checks++;
    if (rx_if.data_out !== 8'h00 || rx_if.valid_out !== 1'b0 ||
        rx_if.byte_stb !== 1'b0 || rx_if.rx_active !== 1'b0) begin
      failures++;
      $display("FAIL async_assert: got data=%02h valid=%0b stb=%0b act=%0b, exp all 0",
               rx_if.data_out, rx_if.valid_out, rx_if.byte_stb, rx_if.rx_active);
    end
    drive_bit(1'b0);
    drive_bit(1'b0);
    reset_L = 1'b1;
    for (int c = 0; c < NEED; c++) begin
      for (int k = 7; k >= 0; k--) begin
        drive_bit(com_b[k]);
        e = model();
        checks++;
        if (rx_if.rx_active !== e.act) begin
          failures++;
          $display("FAIL async_relock com%0d bit%0d: got act=%0b exp %0b", c, k, rx_if.rx_active, e.act);
        end
      end
      checks++;
      if (rx_if.rx_active !== (c == NEED - 1)) begin
        failures++;
        $display("FAIL async_relock_com%0d: got act=%0b exp %0b", c, rx_if.rx_active, c == NEED - 1);
      end
    end
  endtask

  task automatic test_random_traffic();
    logic [7:0] com_b = COM_SYMBOL;
    exp_t       e;
    for (int rnd = 0; rnd < 3; rnd++) begin
      int pre = $urandom_range(0, 20);
      pulse_reset();
      for (int i = 0; i < pre; i++) drive_bit(1'b0);
      for (int c = 0; c < NEED; c++)
        for (int k = 7; k >= 0; k--) drive_bit(com_b[k]);
      for (int b = 0; b < 40; b++) begin
        logic [7:0] v = ($urandom_range(0, 3) == 0) ? COM_SYMBOL : 8'($urandom);
        for (int k = 7; k >= 0; k--) begin
          drive_bit(v[k]);
          e = model();
          checks++;
          if (rx_if.rx_active !== e.act || rx_if.byte_stb !== e.stb ||
              rx_if.data_out !== e.data || rx_if.valid_out !== e.valid) begin
            failures++;
            $display("FAIL random r%0d byte%0d bit%0d: got act=%0b stb=%0b data=%02h valid=%0b, exp %0b %0b %02h %0b",
                     rnd, b, k, rx_if.rx_active, rx_if.byte_stb, rx_if.data_out, rx_if.valid_out,
                     e.act, e.stb, e.data, e.valid);
          end
        end
      end
    end
  endtask

  initial begin
    rx_if.data_in = 1'b0;
    test_reset();
    test_lock();
    test_data();
    test_idle();
    test_broken_align();
    test_async_reset();
    test_random_traffic();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
